// File: rtl/shiftreg_arb_ctrl.sv
// Two-requester arbiter and controller for one external parallel-load shift register.
// Runs a full-duplex, MSB-first serial transfer and returns the captured word to its owner.
module shiftreg_arb_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic               clock,
    input  logic               sclr,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [WIDTH-1:0]   sr_data,
    output logic               sr_load,
    output logic               sr_enable,
    output logic               sr_shiftin,
    output logic               sr_sclr,
    input  logic [WIDTH-1:0]   sr_q,
    input  logic               sr_shiftout,
    input  logic               ser_in,
    output logic               ser_out,
    output logic               ser_frame,
    output logic               ser_strobe
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             rr_q, rr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;

    logic [1:0] grant;
    logic       strobe;

    // Round-robin pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign strobe = (state_q == SHIFT) && (div_q == DIV_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        rr_d    = rr_q;
        data_d  = data_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    data_d  = grant[1] ? req_data[WIDTH +: WIDTH]
                                       : req_data[0 +: WIDTH];
                    id_d    = grant[1];
                    rr_d    = ~grant[1];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                div_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (strobe) begin
                    div_d = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            rr_q    <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign req_ready  = grant;
    assign sr_data    = data_q;
    assign sr_load    = (state_q == LOAD);
    assign sr_enable  = (state_q == LOAD) || strobe;
    assign sr_shiftin = (state_q == SHIFT) && ser_in;
    assign sr_sclr    = sclr;
    assign ser_out    = (state_q == SHIFT) && sr_shiftout;
    assign ser_frame  = (state_q == SHIFT);
    assign ser_strobe = strobe;
    assign rsp_valid  = (state_q == DONE);
    assign rsp_id     = id_q;
    assign rsp_data   = (state_q == DONE) ? sr_q : '0;

endmodule

// File: doc/shiftreg_arb_ctrl.md
Name: shiftreg_arb_ctrl

Overview:
- Controller and arbiter that shares one external parallel-load shift register between two requesters.
- Accepts a parallel word from the winning requester and drives the register's load/enable/shiftin controls.
- Streams the word out serially while capturing ser_in, then returns the captured word to the same requester.
- Sits between GPU-side command sources and a serial link (SPI-style full duplex, MSB first, LEFT direction).

Parameters:
- WIDTH, 8, shift register width in bits; must be 2..32.
- DIV, 1, clocks per shift; 1..255; one shift pulse per DIV cycles.
- CNT_W, derived as clog2(WIDTH+1), localparam for the bit counter; not overridable.

Ports:
- clock  in  1  sole clock, rising edge.
- sclr  in  1  synchronous active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_data  in  2*WIDTH  request words; requester i occupies bits [i*WIDTH +: WIDTH].
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester index that owns the response.
- rsp_data  out  WIDTH  captured serial-in word.
- sr_data  out  WIDTH  parallel data to the shift register.
- sr_load  out  1  shift register load.
- sr_enable  out  1  shift register clock enable.
- sr_shiftin  out  1  shift register serial input.
- sr_sclr  out  1  shift register synchronous clear.
- sr_q  in  WIDTH  shift register parallel output.
- sr_shiftout  in  1  shift register MSB (serial out).
- ser_in  in  1  serial link input.
- ser_out  out  1  serial link output.
- ser_frame  out  1  high for the whole transfer (SHIFT state).
- ser_strobe  out  1  high on each cycle where a shift occurs.

Behaviour:
- Reset (sclr=1 at an edge):
  - state goes to IDLE; bit counter, divider counter and grant register cleared; rr pointer set to requester 0.
  - All outputs are 0 from the cycle after reset.
  - sr_sclr is combinationally equal to sclr.
- Reset mid-transfer: the transfer is aborted, no response is produced, and the shift register is cleared via sr_sclr.
- States: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE:
  - req_ready = grant, combinational from req_valid and the rr pointer.
  - Only one valid requester: that requester is granted.
  - Both valid: the requester at the rr pointer is granted.
  - On accept (valid&ready), latch req_data[grant] into the sr_data register and grant into rsp_id; rr pointer flips to the non-granted index; go to LOAD.
  - req_ready is 0 in every other state.
- LOAD (1 cycle): sr_load=1, sr_enable=1. Next state SHIFT; counters cleared.
- SHIFT:
  - ser_frame=1; sr_load=0; ser_out = sr_shiftout (combinational); sr_shiftin = ser_in.
  - The divider counts 0..DIV-1. On count DIV-1: sr_enable=1, ser_strobe=1, bit counter +1, divider wraps to 0.
  - At all other times sr_enable=0.
  - After the WIDTH-th strobe, go to DONE.
- DONE:
  - rsp_valid=1, rsp_data=sr_q; held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE; the pointer update is already done.
  - rsp_ready is a don't-care outside DONE.
- Latency: accept at cycle T gives rsp_valid high at T+2+WIDTH*DIV. Back-to-back throughput is one transfer per 3+WIDTH*DIV cycles with rsp_ready=1.
- Bit order: bit WIDTH-1 is transmitted first; the first ser_in bit sampled lands in rsp_data[WIDTH-1].
- sr_data holds its value outside LOAD; the shift register ignores it when sr_load=0.
- Counter widths never wrap within a transfer; WIDTH is reached exactly.

Test Plan:
- Reset then single request: WIDTH=8, DIV=1, req0 data=0xA5, ser_in looped from ser_out -> ser_out sequence 1,0,1,0,0,1,0,1; rsp_valid at accept+10; rsp_data=0xA5; rsp_id=0.
- Simultaneous requests: req0=0x12, req1=0x34 both held valid -> order of grants 0,1,0,1; each rsp_id matches the owner; req_ready never two-hot.
- Divider: DIV=3, ser_in tied 1 -> ser_strobe every 3rd cycle, exactly 8 strobes; rsp_valid at accept+26; rsp_data=0xFF.
- Response backpressure: rsp_ready low for 5 cycles in DONE -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0 with req1 valid; grant occurs the cycle after the handshake.
- Reset mid-SHIFT after 3 strobes -> sr_sclr=1 that cycle; next cycle IDLE, all outputs 0, no rsp_valid; rr pointer back to 0.
- Idle no-request: req_valid=0 for 20 cycles -> sr_enable, sr_load, ser_frame all 0; state remains IDLE.
